// File: rtl/div_rem_sequencer_if.sv
// Request/response bundle between an issuing pipeline and the M-extension divide/remainder sequencer.
interface div_rem_sequencer_if;
  logic        i_valid;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [4:0]  i_rd;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_busy;

  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_rd, i_flush,
    input  o_valid, o_result, o_rd, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_rd, i_flush,
    output o_valid, o_result, o_rd, o_busy
  );
endinterface

// File: rtl/div_rem_sequencer.sv
// Wraps a pipelined unsigned divider to implement RISC-V DIV/DIVU/REM/REMU, including
// sign fix-up, divide-by-zero and overflow results, flush and in-order completion.
module div_rem_sequencer #(
  parameter int LATENCY = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  div_rem_sequencer_if.slave        bus,
  output logic [31:0]               div_dividend,
  output logic [31:0]               div_divisor,
  input  logic [31:0]               div_quotient,
  input  logic [31:0]               div_remainder
);

  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] rs1;
    logic [4:0]  rd;
  } meta_t;

  meta_t       pipe [LATENCY];
  meta_t       entry;
  meta_t       tail;
  logic        is_signed;
  logic [31:0] result;
  logic        busy;

  // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    is_signed    = ~bus.i_op[0];
    div_dividend = bus.i_rs1;
    div_divisor  = bus.i_rs2;
    if (is_signed && bus.i_rs1[31]) div_dividend = 32'd0 - bus.i_rs1;
    if (is_signed && bus.i_rs2[31]) div_divisor  = 32'd0 - bus.i_rs2;
  end

  always_comb begin
    entry       = '0;
    entry.valid = bus.i_valid & ~bus.i_flush;
    entry.op    = bus.i_op;
    entry.neg_q = is_signed & (bus.i_rs1[31] ^ bus.i_rs2[31]);
    entry.neg_r = is_signed & bus.i_rs1[31];
    entry.dz    = (bus.i_rs2 == 32'd0);
    entry.rs1   = bus.i_rs1;
    entry.rd    = bus.i_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= entry;
      for (int k = 1; k < LATENCY; k++) begin
        pipe[k] <= pipe[k-1];
        if (bus.i_flush) pipe[k].valid <= 1'b0;
      end
    end
  end

  // The tail entry lines up with the divider outputs for the same op.
  always_comb begin
    tail   = pipe[LATENCY-1];
    result = div_quotient;
    if (tail.op[1]) begin
      if (tail.dz)         result = tail.rs1;
      else if (tail.neg_r) result = 32'd0 - div_remainder;
      else                 result = div_remainder;
    end else begin
      if (tail.dz)         result = 32'hFFFF_FFFF;
      else if (tail.neg_q) result = 32'd0 - div_quotient;
      else                 result = div_quotient;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid  <= 1'b0;
      bus.o_result <= 32'd0;
      bus.o_rd     <= 5'd0;
    end else if (bus.i_flush) begin
      bus.o_valid <= 1'b0;
    end else begin
      bus.o_valid <= tail.valid;
      if (tail.valid) begin
        bus.o_result <= result;
        bus.o_rd     <= tail.rd;
      end
    end
  end

  always_comb begin
    busy = bus.o_valid;
    for (int k = 0; k < LATENCY; k++) busy = busy | pipe[k].valid;
    bus.o_busy = busy;
  end

endmodule

// File: doc/div_rem_sequencer.md
DIV_REM_SEQUENCER -- requirements
Module: div_rem_sequencer

Interface
REQ-001 Parameter LATENCY, default 7, SHALL be the unsigned divider's cycles from operand presentation to valid div_quotient/div_remainder.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, SHALL be synchronous and active-high.
REQ-004 i_valid  input  1  a new divide/remainder op is presented this cycle.
REQ-005 i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of the M-extension ops).
REQ-006 i_rs1  input  32  dividend, two's complement for DIV/REM.
REQ-007 i_rs2  input  32  divisor, two's complement for DIV/REM.
REQ-008 i_rd  input  5  destination register tag.
REQ-009 i_flush  input  1  kill every in-flight op.
REQ-010 div_dividend  output  32  unsigned dividend to the pipelined unsigned divider.
REQ-011 div_divisor  output  32  unsigned divisor to the divider.
REQ-012 div_quotient  input  32  divider quotient, LATENCY cycles after presentation.
REQ-013 div_remainder  input  32  divider remainder, same timing.
REQ-014 o_valid  output  1  o_result/o_rd valid this cycle.
REQ-015 o_result  output  32  final RISC-V result.
REQ-016 o_rd  output  5  destination tag of o_result.
REQ-017 o_busy  output  1  at least one op in flight or o_valid high.

Function
REQ-018 Operand conditioning SHALL be combinational in the i_valid cycle: signed ops drive div_dividend/div_divisor with absolute values; unsigned ops pass i_rs1/i_rs2 unchanged.
REQ-019 abs(0x80000000) SHALL be 0x80000000 (treated as unsigned magnitude).
REQ-020 The block SHALL accept one op per cycle with no stall; no input ready signal exists.
REQ-021 A LATENCY-deep metadata shift register SHALL carry per op: valid, op, neg_q (signed op, rs1 and rs2 signs differ), neg_r (signed op, rs1 negative), dz (rs2 == 0), original rs1, rd.
REQ-022 The tail entry SHALL align with div_quotient/div_remainder; the result SHALL be registered, so o_valid asserts exactly LATENCY+1 cycles after the accepting cycle.
REQ-023 DIV/DIVU result: dz ? 0xFFFFFFFF : (neg_q ? -div_quotient : div_quotient), modulo 2^32.
REQ-024 REM/REMU result: dz ? original rs1 : (neg_r ? -div_remainder : div_remainder).
REQ-025 Overflow 0x80000000 DIV 0xFFFFFFFF SHALL yield 0x80000000; REM of the same SHALL yield 0.
REQ-026 Back-to-back ops SHALL emerge in issue order, one per cycle, with no interference.
REQ-027 i_flush SHALL clear every metadata valid bit and o_valid on the next edge; an op presented with i_flush high SHALL be dropped.
REQ-028 Ops accepted the cycle after i_flush SHALL complete normally.
REQ-029 o_result/o_rd SHALL hold their last value while o_valid is low.
REQ-030 o_busy SHALL be the OR of all metadata valid bits and o_valid.

Reset
REQ-031 While rst is high: all metadata valid bits, o_valid, o_result and o_rd SHALL be 0 on the next edge.
REQ-032 rst SHALL dominate i_valid and i_flush; ops in flight during reset SHALL never produce o_valid.
REQ-033 The first op SHALL be accepted in the first cycle with rst low.

Verification
REQ-034 DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=5 -> with LATENCY=7, o_valid at cycle 8, o_result=0xFFFFFFFD, o_rd=5; REM same operands -> 0xFFFFFFFF.
REQ-035 DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC; REMU -> 1.
REQ-036 Divide by zero, rs1=0x00001234, rs2=0: DIV -> 0xFFFFFFFF, DIVU -> 0xFFFFFFFF, REM -> 0x00001234, REMU -> 0x00001234.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-038 Eight back-to-back ops with rd=1..8 -> eight consecutive o_valid cycles, correct results, rd order 1..8.
REQ-039 Two ops in flight, then i_flush for 1 cycle -> neither completes, o_busy low one cycle later; op issued the next cycle completes LATENCY+1 cycles later; repeat with rst in place of i_flush -> same drop, and outputs read 0.
